// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the sequencer state encoding, the clock-enable divider modulus
// and the divider values at which each clock enable fires.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_RUN    = 2'd2
    } seq_state_t;

    localparam int          DIV_MOD  = 48;
    localparam int          DIV_W    = 6;
    localparam logic [5:0]  DIV_LAST = 6'(DIV_MOD - 1);

    // Low-order divider bit patterns that trigger each enable.
    localparam logic [1:0]  CE24_MATCH  = 2'd3;
    localparam logic [2:0]  CE12_MATCH  = 3'd7;
    localparam logic [3:0]  CE6_MATCH   = 4'd15;
    localparam logic [3:0]  CE6B_MATCH  = 4'd7;
    localparam logic [5:0]  CE4_MATCH   = 6'd23;

    // ce_4m fires twice per divider period: at CE4_MATCH and half a period later.
    function automatic logic ce4_hit(input logic [5:0] div);
        return (div == CE4_MATCH) || (div == CE4_MATCH + 6'(DIV_MOD / 2));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Async active-low reset clears both stages to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: waits for a stable synchronized PLL lock, releases
// the core reset and generates divided single-cycle clock enables.
// Optional macro PLL_LOCK_LOSS_RESET_EN: when defined, losing lock in RUN
// drops back to WAIT; when undefined, RUN is kept and only lock_lost is set.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 4096
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic reset_req,
    output logic sys_rst_n,
    output logic ce_24m,
    output logic ce_12m,
    output logic ce_6m,
    output logic ce_6mb,
    output logic ce_4m,
    output logic lock_lost
);

    localparam int               CNT_W    = $clog2(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    logic             locked_s;
    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_cnt_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             in_run;

    sync_2ff u_lock_sync (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign in_run = (state == ST_RUN);

    // Next-state and stability counter logic; a soft reset request in WAIT
    // keeps the sequencer in WAIT, and lock loss always beats a request.
    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = '0;
        case (state)
            ST_WAIT: begin
                if (locked_s && !reset_req) begin
                    state_nxt = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT;
                end else if (reset_req) begin
                    stab_cnt_nxt = '0;
                end else if (stab_cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    stab_cnt_nxt = stab_cnt + 1'b1;
                end
            end
            ST_RUN: begin
`ifdef PLL_LOCK_LOSS_RESET_EN
                if (!locked_s) begin
                    state_nxt = ST_WAIT;
                end else if (reset_req) begin
                    state_nxt = ST_STABLE;
                end
`else
                if (reset_req) begin
                    state_nxt = ST_STABLE;
                end
`endif
            end
            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

    // State, stability counter and core reset register; sys_rst_n mirrors RUN.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            stab_cnt  <= '0;
            sys_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            stab_cnt  <= stab_cnt_nxt;
            sys_rst_n <= (state_nxt == ST_RUN);
        end
    end

    // Mod-48 divider: zero on the first RUN cycle, counting only while RUN continues.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (in_run && (state_nxt == ST_RUN)) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 6'd1;
        end else begin
            div_cnt <= '0;
        end
    end

    // Clock enables registered from the divider, gated by the current RUN state.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ce_24m <= 1'b0;
            ce_12m <= 1'b0;
            ce_6m  <= 1'b0;
            ce_6mb <= 1'b0;
            ce_4m  <= 1'b0;
        end else begin
            ce_24m <= in_run && (div_cnt[1:0] == CE24_MATCH);
            ce_12m <= in_run && (div_cnt[2:0] == CE12_MATCH);
            ce_6m  <= in_run && (div_cnt[3:0] == CE6_MATCH);
            ce_6mb <= in_run && (div_cnt[3:0] == CE6B_MATCH);
            ce_4m  <= in_run && ce4_hit(div_cnt);
        end
    end

    // Sticky lock-lost flag; a new loss in RUN wins over a clearing request.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost <= 1'b0;
        end else if (in_run && !locked_s) begin
            lock_lost <= 1'b1;
        end else if (reset_req) begin
            lock_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with LOCK_STABLE_CYCLES=8.
// Stimulus pushes expected outputs from a behavioural model into a queue;
// a monitor pops and compares one entry after every clock edge.
// Honours PLL_LOCK_LOSS_RESET_EN the same way as the design.
module tb_pll_reset_seq;

    localparam int N   = 8;
    localparam int MOD = 48;

    localparam int M_WAIT   = 0;
    localparam int M_STABLE = 1;
    localparam int M_RUN    = 2;

    logic clk_sys    = 1'b0;
    logic rst_n      = 1'b0;
    logic pll_locked = 1'b0;
    logic reset_req  = 1'b0;
    logic sys_rst_n;
    logic ce_24m, ce_12m, ce_6m, ce_6mb, ce_4m;
    logic lock_lost;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [6:0] exp_q[$];
    logic [6:0] mon_e;
    logic [6:0] mon_a;

    // Behavioural model state
    bit m_pipe[$];
    int m_mode;
    int m_cnt;
    int m_run;
    bit m_ll;

    pll_reset_seq #(.LOCK_STABLE_CYCLES(N)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .reset_req  (reset_req),
        .sys_rst_n  (sys_rst_n),
        .ce_24m     (ce_24m),
        .ce_12m     (ce_12m),
        .ce_6m      (ce_6m),
        .ce_6mb     (ce_6mb),
        .ce_4m      (ce_4m),
        .lock_lost  (lock_lost)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [6:0] outVec();
        return {sys_rst_n, ce_24m, ce_12m, ce_6m, ce_6mb, ce_4m, lock_lost};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic modelReset();
        m_pipe = {1'b0, 1'b0};
        m_mode = M_WAIT;
        m_cnt  = 0;
        m_run  = 0;
        m_ll   = 1'b0;
    endtask

    // One clock edge of the reference: lock seen two edges late, N locked
    // cycles to reach RUN, enables derived from cycles spent in RUN.
    task automatic modelStep(input bit pll, input bit req, output logic [6:0] e);
        bit ls, prev_run, c24, c12, c6, c6b, c4;
        int d;
        ls = m_pipe.pop_front();
        m_pipe.push_back(pll);
        prev_run = (m_mode == M_RUN);
        d   = m_run % MOD;
        c24 = prev_run && (d % 4 == 3);
        c12 = prev_run && (d % 8 == 7);
        c6  = prev_run && (d % 16 == 15);
        c6b = prev_run && (d % 16 == 7);
        c4  = prev_run && (d % 24 == 23);
        if (prev_run && !ls) m_ll = 1'b1;
        else if (req) m_ll = 1'b0;
        if (m_mode == M_WAIT) begin
            m_cnt = 0;
            if (ls && !req) m_mode = M_STABLE;
        end else if (m_mode == M_STABLE) begin
            if (!ls) begin
                m_mode = M_WAIT;
                m_cnt  = 0;
            end else if (req) begin
                m_cnt = 0;
            end else if (m_cnt == N - 1) begin
                m_mode = M_RUN;
                m_run  = 0;
            end else begin
                m_cnt++;
            end
        end else begin
`ifdef PLL_LOCK_LOSS_RESET_EN
            if (!ls) begin
                m_mode = M_WAIT;
                m_cnt  = 0;
            end else if (req) begin
                m_mode = M_STABLE;
                m_cnt  = 0;
            end else begin
                m_run++;
            end
`else
            if (req) begin
                m_mode = M_STABLE;
                m_cnt  = 0;
            end else begin
                m_run++;
            end
`endif
        end
        e = {(m_mode == M_RUN), c24, c12, c6, c6b, c4, m_ll};
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected
    // outputs for the following rising edge; rst asserts reset mid-cycle.
    task automatic applyStimulus(input bit pll, input bit req, input bit rst);
        logic [6:0] e;
        @(negedge clk_sys);
        pll_locked = pll;
        reset_req  = req;
        if (rst) begin
            #2 rst_n = 1'b0;
            #1;
            checkOutput("async reset outputs", int'(outVec()), 0);
            modelReset();
            e = '0;
        end else begin
            rst_n = 1'b1;
            modelStep(pll, req, e);
        end
        exp_q.push_back(e);
    endtask

    task automatic readAfterEdge();
        @(posedge clk_sys);
        #2;
    endtask

    // Scoreboard monitor: compare DUT outputs after every rising edge.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = outVec();
                tests++;
                if (mon_a !== mon_e) begin
                    fails++;
                    $display("[TB] FAIL scoreboard cycle %0d: got %b, expected %b (sys_rst_n ce24 ce12 ce6 ce6b ce4 lock_lost)",
                             cyc, mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        int rise;
        int c24, c12, c6, c6b, c4, f6, f6b, ce_pos;
        bit pll_r, req_r, rst_r;

        modelReset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
        readAfterEdge();
        checkOutput("reset state", int'(outVec()), 0);

        // Release with lock present: 2 sync + 1 WAIT + N stable cycles.
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            readAfterEdge();
            if (sys_rst_n === 1'b1) begin
                rise = i;
                break;
            end
        end
        checkOutput("release to sys_rst_n rise", rise, 2 + 1 + N);

        // 96 RUN cycles of enable pulses.
        c24 = 0; c12 = 0; c6 = 0; c6b = 0; c4 = 0; f6 = -1; f6b = -1;
        for (int i = 0; i < 96; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            readAfterEdge();
            if (ce_24m === 1'b1) c24++;
            if (ce_12m === 1'b1) c12++;
            if (ce_6m  === 1'b1) c6++;
            if (ce_6mb === 1'b1) c6b++;
            if (ce_4m  === 1'b1) c4++;
            if (ce_6m  === 1'b1 && f6  < 0) f6  = i;
            if (ce_6mb === 1'b1 && f6b < 0) f6b = i;
        end
        checkOutput("ce_24m pulses in 96", c24, 24);
        checkOutput("ce_12m pulses in 96", c12, 12);
        checkOutput("ce_6m pulses in 96",  c6,  6);
        checkOutput("ce_6mb pulses in 96", c6b, 6);
        checkOutput("ce_4m pulses in 96",  c4,  4);
        checkOutput("ce_6m after ce_6mb offset", f6 - f6b, 8);

        // Lock drops for one cycle while in RUN.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        readAfterEdge();
        checkOutput("lock_lost after drop", int'(lock_lost), 1);
`ifdef PLL_LOCK_LOSS_RESET_EN
        checkOutput("sys_rst_n after drop", int'(sys_rst_n), 0);
`else
        checkOutput("sys_rst_n after drop", int'(sys_rst_n), 1);
`endif

        // Get back to RUN (immediate when lock loss does not reset).
        rise = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            readAfterEdge();
            if (sys_rst_n === 1'b1) begin
                rise = i;
                break;
            end
        end
        checkOutput("back in RUN", int'(rise > 0), 1);

        // Soft reset request in RUN.
        applyStimulus(1'b1, 1'b1, 1'b0);
        readAfterEdge();
        checkOutput("sys_rst_n after reset_req", int'(sys_rst_n), 0);
        checkOutput("lock_lost cleared by reset_req", int'(lock_lost), 0);
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            readAfterEdge();
            if (sys_rst_n === 1'b1) begin
                rise = i;
                break;
            end
        end
        checkOutput("reset_req to sys_rst_n rise", rise, N);
        ce_pos = 0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            readAfterEdge();
            if (ce_24m === 1'b1 && ce_pos == 0) ce_pos = i;
        end
        checkOutput("first ce_24m after restart", ce_pos, 4);

        // Asynchronous reset while running, then lock glitch at STABLE count 5.
        applyStimulus(1'b1, 1'b0, 1'b1);
        rise = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus((i == 7) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            readAfterEdge();
            if (sys_rst_n === 1'b1) begin
                rise = i;
                break;
            end
        end
        // WAIT re-entered at edge 9, relock seen at edge 10, then N stable cycles.
        checkOutput("relock after STABLE drop", rise, 10 + N);

        // Randomized traffic checked by the scoreboard.
        pll_r = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (pll_r) pll_r = ($urandom_range(0, 79) != 0);
            else       pll_r = ($urandom_range(0, 5) == 0);
            req_r = ($urandom_range(0, 39) == 0);
            rst_r = ($urandom_range(0, 399) == 0);
            applyStimulus(pll_r, req_r, rst_r);
        end

        @(posedge clk_sys);
        #3;
        checkOutput("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
